// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        SETTLE,
        UNLOAD
    } state_e;

    // Number of skewed feed cycles needed to stream K operands through an H x W array.
    function automatic int feed_len(input int h, input int w, input int k);
        return k + h + w - 2;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job, array-control and result signals of the sequencer; slave is the sequencer side.
interface systolic_ctrl_if #(
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int inner_dim_p    = 2
);
    localparam int feed_w_lp = $clog2(systolic_ctrl_pkg::feed_len(array_height_p, array_width_p, inner_dim_p) + 1);
    localparam int row_w_lp  = systolic_ctrl_pkg::idx_width(array_height_p);
    localparam int col_w_lp  = systolic_ctrl_pkg::idx_width(array_width_p);

    logic                      en_i;
    logic                      flush_i;
    logic                      valid_i;
    logic                      ready_o;
    logic                      pe_clear_o;
    logic                      pe_en_o;
    logic [array_height_p-1:0] row_valid_o;
    logic [array_width_p-1:0]  col_valid_o;
    logic [feed_w_lp-1:0]      feed_cycle_o;
    logic                      valid_o;
    logic                      yumi_i;
    logic [row_w_lp-1:0]       res_row_o;
    logic [col_w_lp-1:0]       res_col_o;
    logic                      done_o;

    modport master (
        output en_i, flush_i, valid_i, yumi_i,
        input  ready_o, pe_clear_o, pe_en_o, row_valid_o, col_valid_o,
               feed_cycle_o, valid_o, res_row_o, res_col_o, done_o
    );

    modport slave (
        input  en_i, flush_i, valid_i, yumi_i,
        output ready_o, pe_clear_o, pe_en_o, row_valid_o, col_valid_o,
               feed_cycle_o, valid_o, res_row_o, res_col_o, done_o
    );

endinterface

// File: rtl/systolic_ctrl_skew_mask_gen.sv
// Skewed operand-valid mask: lane l is live for feed cycles l .. l+K-1.
module skew_mask_gen #(
    parameter int lanes_p     = 2,
    parameter int inner_dim_p = 2,
    parameter int cnt_w_p     = 3
) (
    input  logic [cnt_w_p-1:0] t_i,
    input  logic               en_i,
    output logic [lanes_p-1:0] mask_o
);

    generate
        for (genvar gi = 0; gi < lanes_p; gi++) begin : g_lane
            assign mask_o[gi] = en_i && (int'(t_i) >= gi) && (int'(t_i) < gi + inner_dim_p);
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the systolic array: clear, skewed feed, settle, then row-major result unload.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int inner_dim_p    = 2
) (
    input logic           clk_i,
    input logic           reset_i,
    systolic_ctrl_if.slave bus
);

    localparam int feed_len_lp = feed_len(array_height_p, array_width_p, inner_dim_p);
    localparam int feed_w_lp   = $clog2(feed_len_lp + 1);
    localparam int row_w_lp    = idx_width(array_height_p);
    localparam int col_w_lp    = idx_width(array_width_p);

    localparam logic [feed_w_lp-1:0] t_last_lp   = feed_w_lp'(feed_len_lp - 1);
    localparam logic [row_w_lp-1:0]  row_last_lp = row_w_lp'(array_height_p - 1);
    localparam logic [col_w_lp-1:0]  col_last_lp = col_w_lp'(array_width_p - 1);

    generate
        if (width_p < 1 || inner_dim_p < 1) begin : g_param_chk
            $error("systolic_ctrl: width_p and inner_dim_p must be >= 1");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [feed_w_lp-1:0] t_q, t_d;
    logic [row_w_lp-1:0]  row_q, row_d;
    logic [col_w_lp-1:0]  col_q, col_d;
    logic                 last_coord;
    logic                 mask_en;

    assign last_coord = (row_q == row_last_lp) && (col_q == col_last_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            t_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Counters return to zero on every exit so they read 0 outside their own state.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        row_d   = row_q;
        col_d   = col_q;
        if (bus.flush_i) begin
            state_d = IDLE;
            t_d     = '0;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) state_d = CLEAR;
                end
                CLEAR: begin
                    state_d = FEED;
                    t_d     = '0;
                end
                FEED: begin
                    if (bus.en_i) begin
                        if (t_q == t_last_lp) begin
                            state_d = SETTLE;
                            t_d     = '0;
                        end else begin
                            t_d = t_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (bus.en_i) begin
                        state_d = UNLOAD;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                UNLOAD: begin
                    if (bus.yumi_i) begin
                        if (col_q == col_last_lp) begin
                            col_d = '0;
                            if (row_q == row_last_lp) begin
                                row_d   = '0;
                                state_d = IDLE;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ready_o      = 1'b0;
        bus.pe_clear_o   = 1'b0;
        bus.pe_en_o      = 1'b0;
        bus.valid_o      = 1'b0;
        bus.done_o       = 1'b0;
        bus.feed_cycle_o = t_q;
        bus.res_row_o    = row_q;
        bus.res_col_o    = col_q;
        mask_en          = 1'b0;
        case (state_q)
            IDLE:   bus.ready_o = 1'b1;
            CLEAR:  bus.pe_clear_o = 1'b1;
            FEED: begin
                bus.pe_en_o = bus.en_i;
                mask_en     = bus.en_i;
            end
            SETTLE: bus.pe_en_o = bus.en_i;
            UNLOAD: begin
                bus.valid_o = 1'b1;
                bus.done_o  = bus.yumi_i && last_coord && !bus.flush_i;
            end
            default: ;
        endcase
    end

    skew_mask_gen #(
        .lanes_p    (array_height_p),
        .inner_dim_p(inner_dim_p),
        .cnt_w_p    (feed_w_lp)
    ) u_row_mask (
        .t_i   (t_q),
        .en_i  (mask_en),
        .mask_o(bus.row_valid_o)
    );

    skew_mask_gen #(
        .lanes_p    (array_width_p),
        .inner_dim_p(inner_dim_p),
        .cnt_w_p    (feed_w_lp)
    ) u_col_mask (
        .t_i   (t_q),
        .en_i  (mask_en),
        .mask_o(bus.col_valid_o)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed vector bench for systolic_ctrl (2x2, K=2) plus a 1x1, K=1 instance.
module tb_systolic_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.array_width_p(2), .array_height_p(2), .inner_dim_p(2)) bus ();
    systolic_ctrl_if #(.array_width_p(1), .array_height_p(1), .inner_dim_p(1)) sbus ();

    systolic_ctrl #(.width_p(8), .array_width_p(2), .array_height_p(2), .inner_dim_p(2)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    systolic_ctrl #(.width_p(8), .array_width_p(1), .array_height_p(1), .inner_dim_p(1)) sdut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (sbus)
    );

    typedef struct packed {
        logic en, fl, vi, yu;
    } in_t;

    typedef struct packed {
        logic       rdy, clr, pen;
        logic [1:0] rv, cv;
        logic [2:0] fc;
        logic       vo, rr, rc, dn;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic en, fl, vi, yu, rdy, clr, pen,
                                input logic [1:0] rv, cv, input logic [2:0] fc,
                                input logic vo, rr, rc, dn);
        vec_t v;
        v.in  = '{en: en, fl: fl, vi: vi, yu: yu};
        v.exp = '{rdy: rdy, clr: clr, pen: pen, rv: rv, cv: cv, fc: fc, vo: vo, rr: rr, rc: rc, dn: dn};
        return v;
    endfunction

    // Per-state row builders; every expected field is spelled out by the caller or fixed here.
    function automatic vec_t idl(input logic en, fl, vi, yu);
        return mk(en, fl, vi, yu, 1, 0, 0, 2'b00, 2'b00, 3'd0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t clrr(input logic en, fl, vi, yu);
        return mk(en, fl, vi, yu, 0, 1, 0, 2'b00, 2'b00, 3'd0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t fd(input logic en, fl, vi, yu, input logic [1:0] m, input logic [2:0] t);
        return mk(en, fl, vi, yu, 0, 0, en, m, m, t, 0, 0, 0, 0);
    endfunction
    function automatic vec_t st(input logic en, fl, vi, yu);
        return mk(en, fl, vi, yu, 0, 0, en, 2'b00, 2'b00, 3'd0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t ul(input logic en, fl, vi, yu, rr, rc, dn);
        return mk(en, fl, vi, yu, 0, 0, 0, 2'b00, 2'b00, 3'd0, 1, rr, rc, dn);
    endfunction

    task automatic add_basic_job();
        vq.push_back(idl(1, 0, 1, 1));
        vq.push_back(clrr(1, 0, 0, 1));
        vq.push_back(fd(1, 0, 0, 1, 2'b01, 3'd0));
        vq.push_back(fd(1, 0, 0, 1, 2'b11, 3'd1));
        vq.push_back(fd(1, 0, 0, 1, 2'b10, 3'd2));
        vq.push_back(fd(1, 0, 0, 1, 2'b00, 3'd3));
        vq.push_back(st(1, 0, 0, 1));
        vq.push_back(ul(1, 0, 0, 1, 0, 0, 0));
        vq.push_back(ul(1, 0, 0, 1, 0, 1, 0));
        vq.push_back(ul(1, 0, 0, 1, 1, 0, 0));
        vq.push_back(ul(1, 0, 0, 1, 1, 1, 1));
        vq.push_back(idl(1, 0, 0, 1));
    endtask

    function automatic out_t sample();
        out_t o;
        o.rdy = bus.ready_o;
        o.clr = bus.pe_clear_o;
        o.pen = bus.pe_en_o;
        o.rv  = bus.row_valid_o;
        o.cv  = bus.col_valid_o;
        o.fc  = bus.feed_cycle_o;
        o.vo  = bus.valid_o;
        o.rr  = bus.res_row_o;
        o.rc  = bus.res_col_o;
        o.dn  = bus.done_o;
        return o;
    endfunction

    task automatic check(input string name, input int idx, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] (rdy clr pen rv cv fc vo rr rc dn): got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        bus.en_i    = i.en;
        bus.flush_i = i.fl;
        bus.valid_i = i.vi;
        bus.yumi_i  = i.yu;
    endtask

    task automatic step(input string name, input int idx, input vec_t v);
        @(negedge clk);
        drive(v.in);
        #1;
        check(name, idx, sample(), v.exp);
    endtask

    logic [9:0] s_exp[6];
    logic [9:0] s_act;

    initial begin
        drive('{en: 1'b1, fl: 1'b0, vi: 1'b0, yu: 1'b0});
        sbus.en_i = 1'b1; sbus.flush_i = 1'b0; sbus.valid_i = 1'b0; sbus.yumi_i = 1'b0;

        // Scenario 1 body: five idle cycles after reset.
        for (int i = 0; i < 5; i++) vq.push_back(idl(1, 0, 0, 0));
        // Scenario 2: plain job, yumi held high.
        add_basic_job();
        // Scenario 3: two stalled feed cycles at t=1.
        vq.push_back(idl(1, 0, 1, 0));
        vq.push_back(clrr(1, 0, 0, 0));
        vq.push_back(fd(1, 0, 0, 0, 2'b01, 3'd0));
        vq.push_back(fd(0, 0, 0, 0, 2'b00, 3'd1));
        vq.push_back(fd(0, 0, 0, 0, 2'b00, 3'd1));
        vq.push_back(fd(1, 0, 0, 0, 2'b11, 3'd1));
        vq.push_back(fd(1, 0, 0, 0, 2'b10, 3'd2));
        vq.push_back(fd(1, 0, 0, 0, 2'b00, 3'd3));
        vq.push_back(st(1, 0, 0, 1));
        vq.push_back(ul(1, 0, 0, 1, 0, 0, 0));
        vq.push_back(ul(1, 0, 0, 1, 0, 1, 0));
        vq.push_back(ul(1, 0, 0, 1, 1, 0, 0));
        vq.push_back(ul(1, 0, 0, 1, 1, 1, 1));
        vq.push_back(idl(1, 0, 0, 0));
        // Scenario 4: backpressure at (0,1), en low in CLEAR/SETTLE/UNLOAD, stray yumi before unload.
        vq.push_back(idl(1, 0, 1, 1));
        vq.push_back(clrr(0, 0, 0, 1));
        vq.push_back(fd(1, 0, 0, 1, 2'b01, 3'd0));
        vq.push_back(fd(1, 0, 0, 1, 2'b11, 3'd1));
        vq.push_back(fd(1, 0, 0, 1, 2'b10, 3'd2));
        vq.push_back(fd(1, 0, 0, 1, 2'b00, 3'd3));
        vq.push_back(st(0, 0, 0, 1));
        vq.push_back(st(1, 0, 0, 1));
        vq.push_back(ul(0, 0, 0, 1, 0, 0, 0));
        vq.push_back(ul(0, 0, 0, 0, 0, 1, 0));
        vq.push_back(ul(0, 0, 0, 0, 0, 1, 0));
        vq.push_back(ul(0, 0, 0, 0, 0, 1, 0));
        vq.push_back(ul(0, 0, 0, 1, 0, 1, 0));
        vq.push_back(ul(0, 0, 0, 1, 1, 0, 0));
        vq.push_back(ul(0, 0, 0, 1, 1, 1, 1));
        vq.push_back(idl(1, 0, 0, 0));
        // Scenario 5: flush in FEED at t=2, flush in UNLOAD at (1,0) with yumi, then a clean job.
        vq.push_back(idl(1, 0, 1, 0));
        vq.push_back(clrr(1, 0, 0, 0));
        vq.push_back(fd(1, 0, 0, 0, 2'b01, 3'd0));
        vq.push_back(fd(1, 0, 0, 0, 2'b11, 3'd1));
        vq.push_back(fd(1, 1, 0, 0, 2'b10, 3'd2));
        vq.push_back(idl(1, 0, 0, 0));
        vq.push_back(idl(1, 0, 1, 1));
        vq.push_back(clrr(1, 0, 0, 1));
        vq.push_back(fd(1, 0, 0, 1, 2'b01, 3'd0));
        vq.push_back(fd(1, 0, 0, 1, 2'b11, 3'd1));
        vq.push_back(fd(1, 0, 0, 1, 2'b10, 3'd2));
        vq.push_back(fd(1, 0, 0, 1, 2'b00, 3'd3));
        vq.push_back(st(1, 0, 0, 1));
        vq.push_back(ul(1, 0, 0, 1, 0, 0, 0));
        vq.push_back(ul(1, 0, 0, 1, 0, 1, 0));
        vq.push_back(ul(1, 1, 0, 1, 1, 0, 0));
        vq.push_back(idl(1, 0, 0, 0));
        add_basic_job();
        // Scenario 6: valid+flush in IDLE, then valid held through a whole job.
        vq.push_back(idl(1, 1, 1, 0));
        vq.push_back(idl(1, 0, 0, 0));
        vq.push_back(idl(1, 0, 1, 1));
        vq.push_back(clrr(1, 0, 1, 1));
        vq.push_back(fd(1, 0, 1, 1, 2'b01, 3'd0));
        vq.push_back(fd(1, 0, 1, 1, 2'b11, 3'd1));
        vq.push_back(fd(1, 0, 1, 1, 2'b10, 3'd2));
        vq.push_back(fd(1, 0, 1, 1, 2'b00, 3'd3));
        vq.push_back(st(1, 0, 1, 1));
        vq.push_back(ul(1, 0, 1, 1, 0, 0, 0));
        vq.push_back(ul(1, 0, 1, 1, 0, 1, 0));
        vq.push_back(ul(1, 0, 1, 1, 1, 0, 0));
        vq.push_back(ul(1, 0, 1, 1, 1, 1, 1));
        vq.push_back(idl(1, 0, 0, 0));
        vq.push_back(idl(1, 0, 0, 0));

        repeat (10) @(negedge clk);
        check("reset", 0, sample(), idl(1, 0, 0, 0).exp);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) step("vec", i, vq[i]);

        // Reset mid-FEED: current-state outputs in the reset cycle, IDLE afterwards.
        step("rst_mid", 0, idl(1, 0, 1, 0));
        step("rst_mid", 1, clrr(1, 0, 0, 0));
        step("rst_mid", 2, fd(1, 0, 0, 0, 2'b01, 3'd0));
        step("rst_mid", 3, fd(1, 0, 0, 0, 2'b11, 3'd1));
        rst = 1'b1;
        step("rst_mid", 4, idl(1, 0, 0, 0));
        rst = 1'b0;
        step("rst_mid", 5, idl(1, 0, 0, 0));

        // Degenerate 1x1, K=1: {rdy clr pen rv cv fc vo rr rc dn}.
        s_exp[0] = 10'b1_0_0_0_0_0_0_0_0_0;
        s_exp[1] = 10'b0_1_0_0_0_0_0_0_0_0;
        s_exp[2] = 10'b0_0_1_1_1_0_0_0_0_0;
        s_exp[3] = 10'b0_0_1_0_0_0_0_0_0_0;
        s_exp[4] = 10'b0_0_0_0_0_0_1_0_0_1;
        s_exp[5] = 10'b1_0_0_0_0_0_0_0_0_0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sbus.valid_i = (i == 0);
            sbus.yumi_i  = 1'b1;
            #1;
            s_act = {sbus.ready_o, sbus.pe_clear_o, sbus.pe_en_o, sbus.row_valid_o, sbus.col_valid_o,
                     sbus.feed_cycle_o, sbus.valid_o, sbus.res_row_o, sbus.res_col_o, sbus.done_o};
            total++;
            if (s_act !== s_exp[i]) begin
                bad++;
                $display("FAIL deg1x1[%0d] (rdy clr pen rv cv fc vo rr rc dn): got %b expected %b", i, s_act, s_exp[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
